// File: rtl/alu_sequencer.sv
// Four-phase instruction sequencer (IDLE/READ/EXEC/WB) that drives an external
// combinational ALU and owns a 16-entry register file plus the latched flags.
module alu_sequencer #(
  parameter int unsigned REGS = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_valid,
  output logic        inst_ready,
  input  logic [15:0] inst,
  output logic [7:0]  alu_opcode,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  output logic        alu_cin,
  input  logic [15:0] alu_c,
  input  logic [4:0]  alu_flags,
  output logic        done,
  output logic        illegal,
  output logic [4:0]  psr,
  input  logic [3:0]  dbg_addr,
  output logic [15:0] dbg_data
);

  typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;

  state_t      state_q, state_d;
  logic [15:0] inst_q;
  logic [15:0] opa_q, opb_d, opb_q;
  logic [15:0] res_q;
  logic [4:0]  psr_q;
  logic [15:0] regs_q [REGS];

  logic [3:0]  cls, rd, ext, rs;
  logic [7:0]  imm8;
  logic        is_reg, is_imm, is_illegal, is_nop, is_cmp, wr_en;

  assign cls  = inst_q[15:12];
  assign rd   = inst_q[11:8];
  assign ext  = inst_q[7:4];
  assign rs   = inst_q[3:0];
  assign imm8 = inst_q[7:0];

  always_comb begin
    is_reg     = (cls == 4'b0000) || (cls == 4'b1000);
    is_imm     = (cls == 4'b0101) || (cls == 4'b0110) || (cls == 4'b0111) ||
                 (cls == 4'b1001) || (cls == 4'b1011);
    is_illegal = !(is_reg || is_imm);
    is_nop     = (inst_q == 16'h0000);
    // Compare forms update flags only; their result is discarded.
    is_cmp     = (cls == 4'b1011) ||
                 ((cls == 4'b0000) && ((ext == 4'b1011) || (ext == 4'b1111)));
    wr_en      = !is_illegal && !is_nop && !is_cmp;
  end

  always_comb begin
    opb_d = '0;
    if (is_reg)
      opb_d = regs_q[rs];
    else if (cls == 4'b0110)
      opb_d = {8'h00, imm8};
    else if (is_imm)
      opb_d = {{8{imm8[7]}}, imm8};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (inst_valid) state_d = READ;
      READ:    state_d = EXEC;
      EXEC:    state_d = WB;
      WB:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    inst_ready = (state_q == IDLE);
    done       = (state_q == WB);
    illegal    = (state_q == WB) && is_illegal;
    alu_opcode = '0;
    alu_a      = '0;
    alu_b      = '0;
    alu_cin    = 1'b0;
    if (state_q == EXEC) begin
      alu_opcode = {cls, ext};
      alu_a      = opa_q;
      alu_b      = opb_q;
      alu_cin    = psr_q[3];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inst_q <= '0;
      opa_q  <= '0;
      opb_q  <= '0;
      res_q  <= '0;
      psr_q  <= '0;
      for (int unsigned i = 0; i < REGS; i++) regs_q[i] <= '0;
    end else begin
      case (state_q)
        IDLE: if (inst_valid) inst_q <= inst;
        READ: begin
          opa_q <= regs_q[rd];
          opb_q <= opb_d;
        end
        EXEC: begin
          res_q <= alu_c;
          if (!is_illegal && !is_nop) psr_q <= alu_flags;
        end
        WB: if (wr_en) regs_q[rd] <= res_q;
        default: ;
      endcase
    end
  end

  assign psr      = psr_q;
  assign dbg_data = regs_q[dbg_addr];

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench: stimulus pushes expected per-instruction outcomes from a
// behavioural ISA model; a monitor pops and checks them on every done pulse.
module tb_alu_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        inst_valid = 1'b0;
  logic        inst_ready;
  logic [15:0] inst = '0;
  logic [7:0]  alu_opcode;
  logic [15:0] alu_a, alu_b, alu_c;
  logic        alu_cin;
  logic [4:0]  alu_flags;
  logic        done, illegal;
  logic [4:0]  psr;
  logic [3:0]  dbg_addr, mon_addr = '0, stim_addr = '0;
  logic        stim_own = 1'b0;
  logic [15:0] dbg_data;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int n_acc = 0;
  int done_cnt = 0;

  typedef struct {
    int          edge_n;
    logic [7:0]  opcode;
    logic [15:0] a, b;
    logic        cin, chk_b, ill;
    logic [4:0]  psr;
    logic [3:0]  rd;
    logic [15:0] rval;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] m_regs [16];
  logic [4:0]  m_psr;

  assign dbg_addr = stim_own ? stim_addr : mon_addr;

  alu_sequencer #(.REGS(16)) dut (
    .clk(clk), .reset(reset), .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst(inst), .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b),
    .alu_cin(alu_cin), .alu_c(alu_c), .alu_flags(alu_flags), .done(done),
    .illegal(illegal), .psr(psr), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Toy ALU used both as the DUT's environment and by the reference model.
  function automatic logic [20:0] alu_fn(input logic [7:0] op, input logic [15:0] a,
                                         input logic [15:0] b, input logic cin);
    logic [3:0]  c4, e4;
    logic        sub, addc, z, cy, v, n, l;
    logic [16:0] r;
    c4   = op[7:4];
    e4   = op[3:0];
    sub  = (c4 == 4'h9) || (c4 == 4'hB) ||
           (c4 == 4'h0 && (e4 == 4'h9 || e4 == 4'hB || e4 == 4'hF));
    addc = (c4 == 4'h7) || (c4 == 4'h0 && e4 == 4'h7);
    if (c4 == 4'h8)   r = {1'b0, a ^ b};
    else if (sub)     r = {1'b0, a} - {1'b0, b};
    else              r = {1'b0, a} + {1'b0, b} + {16'd0, addc & cin};
    z  = (r[15:0] == 16'h0000);
    cy = r[16];
    n  = r[15];
    v  = (c4 == 4'h8) ? 1'b0 :
         sub ? ((a[15] != b[15]) && (r[15] != a[15])) :
               ((a[15] == b[15]) && (r[15] != a[15]));
    l  = sub && ($signed(a) < $signed(b));
    return {z, cy, v, n, l, r[15:0]};
  endfunction

  always_comb {alu_flags, alu_c} = alu_fn(alu_opcode, alu_a, alu_b, alu_cin);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Architectural effect of one instruction, computed from the ISA rules.
  task automatic model_push(input logic [15:0] ins, input int edge_n);
    exp_t        e;
    logic [3:0]  c4, e4, rd, rs;
    logic        is_reg, is_imm, wr;
    logic [20:0] res;
    c4 = ins[15:12]; rd = ins[11:8]; e4 = ins[7:4]; rs = ins[3:0];
    is_reg = (c4 == 4'h0 || c4 == 4'h8);
    is_imm = (c4 inside {4'h5, 4'h6, 4'h7, 4'h9, 4'hB});
    e.edge_n = edge_n;
    e.opcode = {c4, e4};
    e.a      = m_regs[rd];
    e.b      = is_reg ? m_regs[rs] : (c4 == 4'h6) ? {8'h00, ins[7:0]}
                                                  : {{8{ins[7]}}, ins[7:0]};
    e.chk_b  = is_reg || is_imm;
    e.cin    = m_psr[3];
    e.ill    = !(is_reg || is_imm);
    e.rd     = rd;
    res      = alu_fn(e.opcode, e.a, e.b, e.cin);
    wr       = !e.ill && ins != 16'h0000 && c4 != 4'hB &&
               !(c4 == 4'h0 && (e4 == 4'hB || e4 == 4'hF));
    if (!e.ill && ins != 16'h0000) m_psr = res[20:16];
    if (wr) m_regs[rd] = res[15:0];
    e.psr  = m_psr;
    e.rval = m_regs[rd];
    sb.push_back(e);
    n_acc++;
  endtask

  // Called at a falling edge; returns at the falling edge after the handshake.
  task automatic issue(input logic [15:0] ins, output int edge_n);
    int t = 0;
    edge_n = -1;
    inst = ins;
    inst_valid = 1'b1;
    while (!inst_ready && t < 20) begin @(negedge clk); t++; end
    if (!inst_ready) begin
      chk("handshake_timeout", 32'd0, 32'd1);
      inst_valid = 1'b0;
      return;
    end
    edge_n = cyc + 1;
    model_push(ins, edge_n);
    @(negedge clk);
  endtask

  initial begin : monitor
    logic [7:0]  p_op = '0;
    logic [15:0] p_a = '0, p_b = '0;
    logic        p_cin = 1'b0;
    exp_t        e;
    forever begin
      @(negedge clk);
      if (done) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("done_cycle", cyc, e.edge_n + 2);
          chk("illegal", illegal, e.ill);
          chk("psr", psr, e.psr);
          chk("exec_opcode", p_op, e.opcode);
          chk("exec_a", p_a, e.a);
          if (e.chk_b) chk("exec_b", p_b, e.b);
          chk("exec_cin", p_cin, e.cin);
          chk("wb_bus_idle", {alu_opcode, alu_a[7:0], alu_b[7:0]}, 32'd0);
          mon_addr = e.rd;
          done_cnt++;
          @(negedge clk);
          chk("done_one_cycle", done, 1'b0);
          chk("reg_wb", dbg_data, e.rval);
        end
      end else if (illegal) begin
        chk("illegal_without_done", 32'd1, 32'd0);
      end
      p_op = alu_opcode; p_a = alu_a; p_b = alu_b; p_cin = alu_cin;
    end
  end

  initial begin : stimulus
    int e1, e2, t;
    for (int i = 0; i < 16; i++) m_regs[i] = '0;
    m_psr = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_ready", inst_ready, 1'b1);
    chk("rst_done", {done, illegal}, 2'b00);
    chk("rst_psr", psr, 5'd0);
    chk("rst_bus", {alu_opcode, alu_a, alu_cin}, 32'd0);
    stim_own = 1'b1; stim_addr = 4'd7;
    #1 chk("rst_reg7", dbg_data, 16'h0000);
    stim_own = 1'b0;

    // Directed: ADDI, CMP, carry chain into ADDC, immediate extension, illegal, NOP.
    issue(16'h5105, e1); inst_valid = 1'b0;
    issue(16'h5205, e1); inst_valid = 1'b0;
    issue(16'h01B2, e1); inst_valid = 1'b0;
    issue(16'h53FF, e1); inst_valid = 1'b0;
    issue(16'h5301, e1); inst_valid = 1'b0;
    issue(16'h0172, e1); inst_valid = 1'b0;
    issue(16'h51FF, e1); inst_valid = 1'b0;
    issue(16'h61FF, e1); inst_valid = 1'b0;
    issue(16'hF123, e1); inst_valid = 1'b0;
    issue(16'h0000, e1); inst_valid = 1'b0;

    // Back-to-back with inst_valid held: handshakes must be four edges apart.
    issue(16'h5402, e1);
    issue(16'h8414, e2);
    inst_valid = 1'b0;
    chk("b2b_spacing", e2 - e1, 32'd4);

    // Reset while 0x5107 is in EXEC aborts it.
    while (sb.size() != 0) @(negedge clk);
    repeat (2) @(negedge clk);
    issue(16'h5107, e1);
    inst_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    void'(sb.pop_back());
    n_acc--;
    for (int i = 0; i < 16; i++) m_regs[i] = '0;
    m_psr = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("abort_ready", inst_ready, 1'b1);
    chk("abort_psr", psr, 5'd0);
    stim_own = 1'b1; stim_addr = 4'd1;
    #1 chk("abort_r1", dbg_data, 16'h0000);
    stim_own = 1'b0;
    @(negedge clk);

    repeat (150) begin
      issue(16'($urandom()), e1);
      if ($urandom_range(0, 2) == 0) begin
        inst_valid = 1'b0;
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end
    end
    inst_valid = 1'b0;

    t = 0;
    while (sb.size() != 0 && t < 50) begin @(negedge clk); t++; end
    chk("drain", sb.size(), 32'd0);
    repeat (3) @(negedge clk);
    chk("done_count", done_cnt, n_acc);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 SHALL have parameter REGS, default 16, number of general registers (fixed 16; 4-bit register fields).
REQ-002 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have ports inst_valid input 1 / inst_ready output 1 / inst input 16: instruction handshake; transfer when both valid and ready on a clk edge.
REQ-005 SHALL have ports alu_opcode output 8, alu_a output 16, alu_b output 16, alu_cin output 1: operands driven to the combinational ALU.
REQ-006 SHALL have ports alu_c input 16, alu_flags input 5 (ZCFNL: 4 zero, 3 carry, 2 overflow, 1 negative, 0 low): ALU results.
REQ-007 SHALL have ports done output 1 (one-cycle completion pulse), illegal output 1 (one-cycle pulse with done on an undefined class), psr output 5 (latched flags).
REQ-008 SHALL have ports dbg_addr input 4 / dbg_data output 16: combinational register-file read, unaffected by the FSM.

Function
REQ-009 SHALL decode inst as: [15:12] class, [11:8] Rdest, [7:4] ext, [3:0] Rsrc; imm8 = inst[7:0].
REQ-010 SHALL treat classes 0000 and 1000 as register type; classes 0101, 0110, 0111, 1001 and 1011 as immediate; all other classes as illegal.
REQ-011 SHALL implement FSM states IDLE, READ, EXEC, WB; IDLE->READ on handshake; READ->EXEC; EXEC->WB; WB->IDLE unconditionally.
REQ-012 SHALL assert inst_ready only in IDLE; one instruction per 4 cycles; inst captured into an internal register at the handshake.
REQ-013 SHALL in READ latch opA = R[Rdest]; opB = R[Rsrc] for register type, zero-extended imm8 for 0110, sign-extended imm8 for 0101, 0111, 1001 and 1011.
REQ-014 SHALL in EXEC drive alu_opcode = {inst[15:12], inst[7:4]}, alu_a = opA, alu_b = opB, alu_cin = psr[3]; these are 0 in all other states.
REQ-015 SHALL at the EXEC->WB edge latch alu_c into a result register and alu_flags into psr, except for illegal classes and NOP (inst == 16'h0000), which leave psr unchanged.
REQ-016 SHALL in WB write the result to R[Rdest] unless the instruction is illegal, NOP, class 1011 (CMPI), or class 0000 with ext 1011 or 1111 (CMP/CMPU).
REQ-017 SHALL pulse done for exactly the WB cycle of every accepted instruction, legal or not; illegal pulses with done only for illegal classes.
REQ-018 SHALL give Rdest == Rsrc no special handling: operands read in READ, written in WB, so no hazard exists.
REQ-019 SHALL make dbg_data reflect a WB write from the cycle after the write edge.
REQ-020 SHALL ignore inst_valid and inst outside IDLE.

Reset
REQ-021 SHALL on reset asynchronously enter IDLE, clear all 16 registers, psr, the result register and the latched instruction, and drive done = illegal = 0, alu_* = 0, inst_ready = 1 after release.
REQ-022 SHALL abort any in-flight instruction on reset with no register write and no done pulse.

Verification
REQ-023 SHALL pass: inst 0x5105 accepted at cycle 0 -> EXEC at cycle 2 with alu_opcode 0x50, alu_a 0x0000, alu_b 0x0005; model returns C 0x0005, flags 00000 -> done at cycle 3, R1 = 0x0005.
REQ-024 SHALL pass: R1 = 5 and R2 = 5; inst 0x01B2 (CMP R1,R2); model returns flags 10000 -> psr = 10000, R1 still 0x0005, done pulses.
REQ-025 SHALL pass: psr[3] = 1, inst 0x0172 (ADDC R1,R2) -> alu_cin = 1 in EXEC; inst 0x51FF -> alu_b = 0xFFFF; inst 0x61FF -> alu_b = 0x00FF.
REQ-026 SHALL pass: inst 0xF123 -> illegal and done pulse together at cycle 3, registers and psr unchanged.
REQ-027 SHALL pass: reset asserted during EXEC of 0x5107 -> no done pulse, R1 = 0, psr = 0, inst_ready = 1 on the first edge after release.
REQ-028 SHALL pass: inst_valid held high for 8 cycles with two instructions -> exactly two handshakes at cycles 0 and 4, and two done pulses at cycles 3 and 7.
